// File: rtl/ram_dp_sync_pkg.sv
// Shared types and helpers for the dual-port synchronous RAM: FSM states,
// geometry functions and the byte-lane merge used by both ports and the collision logic.
package ram_dp_sync_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Widest word the lane-merge helper handles; callers zero-pad narrower words.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic int calc_nb(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int calc_words(input int mem_size, input int data_width);
    return mem_size / (data_width / 8);
  endfunction

  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] wen_n
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (!wen_n[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_sync_port.sv
// One access port: decode, range check, lane merge against the stored word,
// and the read-data register(s) with optional extra output stage.
module ram_dp_sync_port
  import ram_dp_sync_pkg::*;
#(
  parameter int ADDR_MSB   = 6,
  parameter int DATA_WIDTH = 16,
  parameter int WORDS      = 128,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ready,
  input  logic                    i_cen,
  input  logic [ADDR_MSB:0]       i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_wen,
  input  logic [DATA_WIDTH-1:0]   i_din,
  input  logic [DATA_WIDTH-1:0]   i_rd_word,
  input  logic [DATA_WIDTH-1:0]   i_st_word,
  output logic [ADDR_MSB:0]       o_idx,
  output logic                    o_wr,
  output logic [DATA_WIDTH-1:0]   o_mrg_word,
  output logic [DATA_WIDTH-1:0]   o_dout
);

  localparam int NB = calc_nb(DATA_WIDTH);

  logic                  w_acc;
  logic                  w_inrng;
  logic [MAX_DW-1:0]     w_old_x;
  logic [MAX_DW-1:0]     w_din_x;
  logic [MAX_DW-1:0]     w_mrg_x;
  logic [MAX_NB-1:0]     w_wen_x;
  logic [DATA_WIDTH-1:0] r_dout_p0;

  assign w_acc   = i_ready & ~i_cen;
  assign w_inrng = (int'(i_addr) < WORDS);
  assign o_idx   = w_inrng ? i_addr : '0;
  assign o_wr    = w_acc & w_inrng & ~(&i_wen);

  always_comb begin
    w_old_x = '0;
    w_din_x = '0;
    w_wen_x = '1;
    w_old_x[DATA_WIDTH-1:0] = i_rd_word;
    w_din_x[DATA_WIDTH-1:0] = i_din;
    w_wen_x[NB-1:0]         = i_wen;
    w_mrg_x = lane_merge(w_old_x, w_din_x, w_wen_x);
  end

  assign o_mrg_word = w_mrg_x[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MAX_DW) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = |w_mrg_x[MAX_DW-1:DATA_WIDTH];
  end

  // p0: access stage; a writer sees the final stored word, a reader the old word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dout_p0 <= '0;
    end else if (w_acc) begin
      r_dout_p0 <= !w_inrng ? '0 : (o_wr ? i_st_word : i_rd_word);
    end
  end

  // p1: optional output stage, advances only one cycle after an access.
  if (OUT_REG) begin : g_oreg
    logic                  r_vld_p0;
    logic [DATA_WIDTH-1:0] r_dout_p1;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_vld_p0  <= 1'b0;
        r_dout_p1 <= '0;
      end else begin
        r_vld_p0 <= w_acc;
        if (r_vld_p0) r_dout_p1 <= r_dout_p0;
      end
    end
    assign o_dout = r_dout_p1;
  end else begin : g_noreg
    assign o_dout = r_dout_p0;
  end

endmodule

// File: rtl/ram_dp_sync.sv
// True dual-port single-clock RAM with byte enables, write-collision resolution
// and a clear sequencer that fills every word with INIT_VAL before ports go live.
module ram_dp_sync
  import ram_dp_sync_pkg::*;
#(
  parameter int              ADDR_MSB   = 6,
  parameter int              MEM_SIZE   = 256,
  parameter int              DATA_WIDTH = 16,
  parameter bit              OUT_REG    = 1'b0,
  parameter bit              WR_PRIO    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    ram_clr,
  output logic                    ram_ready,
  output logic                    ram_coll,
  input  logic [ADDR_MSB:0]       ram_addra,
  input  logic                    ram_cena,
  input  logic [DATA_WIDTH/8-1:0] ram_wena,
  input  logic [DATA_WIDTH-1:0]   ram_dina,
  output logic [DATA_WIDTH-1:0]   ram_douta,
  input  logic [ADDR_MSB:0]       ram_addrb,
  input  logic                    ram_cenb,
  input  logic [DATA_WIDTH/8-1:0] ram_wenb,
  input  logic [DATA_WIDTH-1:0]   ram_dinb,
  output logic [DATA_WIDTH-1:0]   ram_doutb
);

  localparam int NB    = calc_nb(DATA_WIDTH);
  localparam int WORDS = calc_words(MEM_SIZE, DATA_WIDTH);

  typedef logic [ADDR_MSB:0] addr_t;
  localparam addr_t LAST_IDX = addr_t'(WORDS - 1);

  state_t                r_state;
  addr_t                 r_clr_cnt;
  logic                  r_ready;
  logic                  r_coll;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_live;
  addr_t                 w_idx_a, w_idx_b;
  logic                  w_wr_a, w_wr_b;
  logic                  w_same, w_coll;
  logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;
  logic [DATA_WIDTH-1:0] w_mrg_a, w_mrg_b;
  logic [DATA_WIDTH-1:0] w_final, w_st_a, w_st_b;
  logic [MAX_DW-1:0]     w_lo_x, w_hi_x, w_fin_x;
  logic [MAX_NB-1:0]     w_hi_wen_x;

  assign w_live = (r_state == ST_READY);
  assign w_rd_a = r_mem[w_idx_a];
  assign w_rd_b = r_mem[w_idx_b];

  ram_dp_sync_port #(
    .ADDR_MSB  (ADDR_MSB),
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS),
    .OUT_REG   (OUT_REG)
  ) u_port_a (
    .i_clk     (mclk),
    .i_rst     (puc_rst),
    .i_ready   (w_live),
    .i_cen     (ram_cena),
    .i_addr    (ram_addra),
    .i_wen     (ram_wena),
    .i_din     (ram_dina),
    .i_rd_word (w_rd_a),
    .i_st_word (w_st_a),
    .o_idx     (w_idx_a),
    .o_wr      (w_wr_a),
    .o_mrg_word(w_mrg_a),
    .o_dout    (ram_douta)
  );

  ram_dp_sync_port #(
    .ADDR_MSB  (ADDR_MSB),
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS),
    .OUT_REG   (OUT_REG)
  ) u_port_b (
    .i_clk     (mclk),
    .i_rst     (puc_rst),
    .i_ready   (w_live),
    .i_cen     (ram_cenb),
    .i_addr    (ram_addrb),
    .i_wen     (ram_wenb),
    .i_din     (ram_dinb),
    .i_rd_word (w_rd_b),
    .i_st_word (w_st_b),
    .o_idx     (w_idx_b),
    .o_wr      (w_wr_b),
    .o_mrg_word(w_mrg_b),
    .o_dout    (ram_doutb)
  );

  assign w_same = w_wr_a & w_wr_b & (w_idx_a == w_idx_b);
  assign w_coll = w_same & (|(~ram_wena & ~ram_wenb));

  // Same-word double write: lay the priority port's lanes over the other port's merge.
  always_comb begin
    w_lo_x     = '0;
    w_hi_x     = '0;
    w_hi_wen_x = '1;
    if (WR_PRIO) begin
      w_lo_x[DATA_WIDTH-1:0] = w_mrg_a;
      w_hi_x[DATA_WIDTH-1:0] = ram_dinb;
      w_hi_wen_x[NB-1:0]     = ram_wenb;
    end else begin
      w_lo_x[DATA_WIDTH-1:0] = w_mrg_b;
      w_hi_x[DATA_WIDTH-1:0] = ram_dina;
      w_hi_wen_x[NB-1:0]     = ram_wena;
    end
    w_fin_x = lane_merge(w_lo_x, w_hi_x, w_hi_wen_x);
  end

  assign w_final = w_fin_x[DATA_WIDTH-1:0];
  assign w_st_a  = w_same ? w_final : w_mrg_a;
  assign w_st_b  = w_same ? w_final : w_mrg_b;

  if (DATA_WIDTH < MAX_DW) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = |w_fin_x[MAX_DW-1:DATA_WIDTH];
  end

  always_ff @(posedge mclk) begin
    if (!w_live) begin
      r_mem[r_clr_cnt] <= INIT_VAL;
    end else begin
      if (w_wr_a) r_mem[w_idx_a] <= w_st_a;
      if (w_wr_b) r_mem[w_idx_b] <= w_st_b;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_coll <= w_coll;
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == LAST_IDX) begin
            r_state   <= ST_READY;
            r_ready   <= 1'b1;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (ram_clr) begin
            r_state   <= ST_CLEAR;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign ram_ready = r_ready;
  assign ram_coll  = r_coll;

endmodule
